// File: rtl/axi_rt_budget_pkg.sv
// Shared types and slot indexing for the AXI real-time budget tracker.
// A slot is one (manager, region, direction) regulation context.
package axi_rt_budget_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } dir_e;

  // Flat slot index: (mgr*num_regions + region)*2 + dir
  function automatic int unsigned slot_idx(input int unsigned mgr,
                                           input int unsigned region,
                                           input int unsigned num_regions,
                                           input dir_e        dir);
    return (mgr * num_regions + region) * 2 + 32'(dir);
  endfunction

endpackage

// File: rtl/axi_rt_budget_slot.sv
// One budget regulation slot: periodic byte-budget refill with optional
// carry-over, consume accounting and a sticky throttle flag.
module axi_rt_budget_slot #(
  parameter int unsigned BudgetWidth = 32,
  parameter int unsigned PeriodWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   carry_i,
  input  logic [BudgetWidth-1:0] budget_i,
  input  logic [PeriodWidth-1:0] period_i,
  input  logic                   cons_valid_i,
  input  logic [BudgetWidth-1:0] cons_bytes_i,
  input  logic                   irq_clear_i,
  output logic                   ready_c,
  output logic [BudgetWidth-1:0] budget_left_o,
  output logic [PeriodWidth-1:0] period_left_o,
  output logic                   exhausted_c,
  output logic                   pending_o
);

  localparam int unsigned SumWidth = BudgetWidth + 1;

  logic [BudgetWidth-1:0] budget_q, budget_d;
  logic [PeriodWidth-1:0] period_q, period_d;
  logic                   pending_q, pending_d;

  logic                   reload;
  logic [SumWidth-1:0]    sum;
  logic [SumWidth-1:0]    cap;
  logic [SumWidth-1:0]    capped;
  logic [BudgetWidth-1:0] reload_val;
  logic [BudgetWidth-1:0] base;
  logic                   fire;
  logic                   throttle;

  // Refill, consume and throttle next-state logic
  always_comb begin
    reload     = enable_i && (period_q == '0);
    sum        = SumWidth'(budget_q) + SumWidth'(budget_i);
    cap        = {budget_i, 1'b0};
    capped     = (sum < cap) ? sum : cap;
    reload_val = budget_i;
    if (carry_i) begin
      reload_val = capped[BudgetWidth] ? '1 : capped[BudgetWidth-1:0];
    end

    // Grant decision always uses the registered (pre-reload) budget
    ready_c  = !enable_i || (budget_q >= cons_bytes_i);
    fire     = enable_i && cons_valid_i && ready_c;
    throttle = enable_i && cons_valid_i && !ready_c;
    base     = reload ? reload_val : budget_q;

    budget_d  = budget_q;
    period_d  = period_q;
    pending_d = pending_q;

    if (!enable_i) begin
      budget_d = '0;
      period_d = '0;
    end else begin
      if (reload) begin
        period_d = (period_i == '0) ? '0 : period_i - PeriodWidth'(1);
        budget_d = reload_val;
      end else begin
        period_d = period_q - PeriodWidth'(1);
      end
      if (fire) begin
        budget_d = (base > cons_bytes_i) ? base - cons_bytes_i : '0;
      end
    end

    // A new throttle event beats a simultaneous clear
    if (throttle) begin
      pending_d = 1'b1;
    end else if (irq_clear_i) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      budget_q  <= '0;
      period_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      budget_q  <= budget_d;
      period_q  <= period_d;
      pending_q <= pending_d;
    end
  end

  assign budget_left_o = budget_q;
  assign period_left_o = period_q;
  assign pending_o     = pending_q;
  assign exhausted_c   = enable_i && (budget_q == '0);

endmodule

// File: rtl/axi_rt_budget_tracker.sv
// Per-manager/region/direction AXI bandwidth budget tracker: routes consume
// requests to their slot, muxes back the grant and ORs the throttle flags.
module axi_rt_budget_tracker
  import axi_rt_budget_pkg::*;
#(
  parameter int unsigned  NumManagers  = 2,
  parameter int unsigned  NumRegions   = 4,
  parameter int unsigned  BudgetWidth  = 32,
  parameter int unsigned  PeriodWidth  = 32,
  localparam int unsigned NumSlots     = NumManagers * NumRegions * 2,
  localparam int unsigned NumReq       = NumManagers * 2,
  localparam int unsigned RegionWidth  = (NumRegions > 1) ? $clog2(NumRegions) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumSlots-1:0]                  enable_i,
  input  logic [NumSlots-1:0]                  carry_i,
  input  logic [NumSlots-1:0][BudgetWidth-1:0] budget_i,
  input  logic [NumSlots-1:0][PeriodWidth-1:0] period_i,
  input  logic [NumReq-1:0]                    cons_valid_i,
  input  logic [NumReq-1:0][RegionWidth-1:0]   cons_region_i,
  input  logic [NumReq-1:0][BudgetWidth-1:0]   cons_bytes_i,
  output logic [NumReq-1:0]                    cons_ready_o,
  output logic [NumSlots-1:0][BudgetWidth-1:0] budget_left_o,
  output logic [NumSlots-1:0][PeriodWidth-1:0] period_left_o,
  output logic [NumSlots-1:0]                  exhausted_o,
  input  logic [NumSlots-1:0]                  irq_clear_i,
  output logic                                 irq_o
);

  localparam int unsigned SlotIdxWidth = $clog2(NumSlots);

  logic [NumSlots-1:0] slot_ready;
  logic [NumSlots-1:0] pending;

  // Request demultiplexer: each manager/direction feeds the slot of its region
  for (genvar gm = 0; gm < NumManagers; gm++) begin : g_mgr
    for (genvar gr = 0; gr < NumRegions; gr++) begin : g_region
      for (genvar gd = 0; gd < 2; gd++) begin : g_dir
        localparam int unsigned Req  = gm * 2 + gd;
        localparam int unsigned Slot = slot_idx(gm, gr, NumRegions, (gd == 0) ? READ : WRITE);

        axi_rt_budget_slot #(
          .BudgetWidth (BudgetWidth),
          .PeriodWidth (PeriodWidth)
        ) u_slot (
          .clk_i         (clk_i),
          .rst_i         (rst_i),
          .enable_i      (enable_i[Slot]),
          .carry_i       (carry_i[Slot]),
          .budget_i      (budget_i[Slot]),
          .period_i      (period_i[Slot]),
          .cons_valid_i  (cons_valid_i[Req] && (cons_region_i[Req] == RegionWidth'(gr))),
          .cons_bytes_i  (cons_bytes_i[Req]),
          .irq_clear_i   (irq_clear_i[Slot]),
          .ready_c       (slot_ready[Slot]),
          .budget_left_o (budget_left_o[Slot]),
          .period_left_o (period_left_o[Slot]),
          .exhausted_c   (exhausted_o[Slot]),
          .pending_o     (pending[Slot])
        );
      end
    end
  end

  // Ready multiplexer; a region code with no slot behind it is never throttled
  for (genvar gm = 0; gm < NumManagers; gm++) begin : g_ready_mgr
    for (genvar gd = 0; gd < 2; gd++) begin : g_ready_dir
      localparam int unsigned Req = gm * 2 + gd;
      localparam dir_e        Dir = (gd == 0) ? READ : WRITE;
      logic ready;

      always_comb begin
        ready = 1'b1;
        for (int unsigned r = 0; r < NumRegions; r++) begin
          if (cons_region_i[Req] == RegionWidth'(r)) begin
            ready = slot_ready[SlotIdxWidth'(slot_idx(gm, r, NumRegions, Dir))];
          end
        end
      end

      assign cons_ready_o[Req] = ready;
    end
  end

  assign irq_o = |pending;

endmodule

// File: tb/tb_axi_rt_budget_tracker.sv
// Self-checking bench: directed scenarios plus random traffic against a
// per-slot arithmetic reference model.
module tb_axi_rt_budget_tracker;

  localparam int unsigned NM = 2;
  localparam int unsigned NR = 4;
  localparam int unsigned BW = 32;
  localparam int unsigned PW = 32;
  localparam int unsigned NS = NM * NR * 2;
  localparam int unsigned NK = NM * 2;
  localparam int unsigned RW = 2;
  localparam longint unsigned MAXV = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_i;
  logic [NS-1:0]          enable_i;
  logic [NS-1:0]          carry_i;
  logic [NS-1:0][BW-1:0]  budget_i;
  logic [NS-1:0][PW-1:0]  period_i;
  logic [NK-1:0]          cons_valid_i;
  logic [NK-1:0][RW-1:0]  cons_region_i;
  logic [NK-1:0][BW-1:0]  cons_bytes_i;
  logic [NK-1:0]          cons_ready_o;
  logic [NS-1:0][BW-1:0]  budget_left_o;
  logic [NS-1:0][PW-1:0]  period_left_o;
  logic [NS-1:0]          exhausted_o;
  logic [NS-1:0]          irq_clear_i;
  logic                   irq_o;

  axi_rt_budget_tracker #(
    .NumManagers (NM),
    .NumRegions  (NR),
    .BudgetWidth (BW),
    .PeriodWidth (PW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .carry_i       (carry_i),
    .budget_i      (budget_i),
    .period_i      (period_i),
    .cons_valid_i  (cons_valid_i),
    .cons_region_i (cons_region_i),
    .cons_bytes_i  (cons_bytes_i),
    .cons_ready_o  (cons_ready_o),
    .budget_left_o (budget_left_o),
    .period_left_o (period_left_o),
    .exhausted_o   (exhausted_o),
    .irq_clear_i   (irq_clear_i),
    .irq_o         (irq_o)
  );

  int errors = 0;
  int checks = 0;

  // Reference state per slot
  longint unsigned m_bl[NS];
  longint unsigned m_pl[NS];
  bit              m_pend[NS];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned slot_of(input int unsigned k);
    int unsigned m, d, r;
    m = k / 2;
    d = k % 2;
    r = 32'(cons_region_i[k]);
    return (m * NR + r) * 2 + d;
  endfunction

  function automatic bit exp_ready(input int unsigned k);
    int unsigned s;
    s = slot_of(k);
    return !enable_i[s] || (m_bl[s] >= 64'(cons_bytes_i[k]));
  endfunction

  // Advance the reference by one clock edge using the current inputs
  task automatic model_step();
    bit              req[NS];
    bit              rdy[NS];
    longint unsigned rb[NS];
    longint unsigned b, sum, rv, base;
    bit              reload;
    for (int s = 0; s < NS; s++) begin
      req[s] = 1'b0;
      rdy[s] = 1'b1;
      rb[s]  = 0;
    end
    for (int unsigned k = 0; k < NK; k++) begin
      if (cons_valid_i[k]) begin
        req[slot_of(k)] = 1'b1;
        rb[slot_of(k)]  = 64'(cons_bytes_i[k]);
        rdy[slot_of(k)] = exp_ready(k);
      end
    end
    for (int s = 0; s < NS; s++) begin
      if (rst_i) begin
        m_bl[s] = 0; m_pl[s] = 0; m_pend[s] = 1'b0;
      end else if (!enable_i[s]) begin
        m_bl[s] = 0; m_pl[s] = 0;
        if (irq_clear_i[s]) m_pend[s] = 1'b0;
      end else begin
        reload = (m_pl[s] == 0);
        b = 64'(budget_i[s]);
        if (carry_i[s]) begin
          sum = m_bl[s] + b;
          rv  = (sum < 2 * b) ? sum : 2 * b;
          if (rv > MAXV) rv = MAXV;
        end else begin
          rv = b;
        end
        base = reload ? rv : m_bl[s];
        if (reload) m_pl[s] = (period_i[s] == 0) ? 0 : 64'(period_i[s]) - 1;
        else        m_pl[s] = m_pl[s] - 1;
        if (req[s] && rdy[s]) m_bl[s] = (base > rb[s]) ? base - rb[s] : 0;
        else                  m_bl[s] = base;
        if (req[s] && !rdy[s]) m_pend[s] = 1'b1;
        else if (irq_clear_i[s]) m_pend[s] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    bit any;
    any = 1'b0;
    for (int s = 0; s < NS; s++) begin
      check($sformatf("budget_left[%0d]", s), 64'(budget_left_o[s]), m_bl[s]);
      check($sformatf("period_left[%0d]", s), 64'(period_left_o[s]), m_pl[s]);
      check($sformatf("exhausted[%0d]", s), 64'(exhausted_o[s]),
            64'(enable_i[s] && (m_bl[s] == 0)));
      any = any | m_pend[s];
    end
    for (int unsigned k = 0; k < NK; k++) begin
      check($sformatf("ready[%0d]", k), 64'(cons_ready_o[k]), 64'(exp_ready(k)));
    end
    check("irq", 64'(irq_o), 64'(any));
  endtask

  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cfg(input int s, input bit en, input bit cy, input int unsigned bud, input int unsigned per);
    enable_i[s] = en;
    carry_i[s]  = cy;
    budget_i[s] = BW'(bud);
    period_i[s] = PW'(per);
  endtask

  task automatic req(input int k, input int unsigned region, input int unsigned bytes);
    cons_valid_i[k]  = 1'b1;
    cons_region_i[k] = RW'(region);
    cons_bytes_i[k]  = BW'(bytes);
  endtask

  task automatic wait_period(input int s, input longint unsigned target);
    for (int i = 0; i < 40; i++) begin
      if (m_pl[s] == target) break;
      step();
    end
  endtask

  initial begin
    rst_i = 1'b1;
    enable_i = '0; carry_i = '0; budget_i = '0; period_i = '0;
    cons_valid_i = '0; cons_region_i = '0; cons_bytes_i = '0; irq_clear_i = '0;
    @(posedge clk);
    #1;
    step();
    check("reset_irq", 64'(irq_o), 64'(0));
    check("reset_exhausted", 64'(exhausted_o), 64'(0));

    // Throttle and reload, no carry (slot 0: m0 r0 read)
    cfg(0, 1'b1, 1'b0, 100, 10);
    rst_i = 1'b0;
    step();
    check("s1_first_reload", 64'(budget_left_o[0]), 64'd100);
    req(0, 0, 60);
    #1 check("s1_ready_first", 64'(cons_ready_o[0]), 64'd1);
    step();
    check("s1_after_60", 64'(budget_left_o[0]), 64'd40);
    #1 check("s1_ready_second", 64'(cons_ready_o[0]), 64'd0);
    step();
    cons_valid_i = '0;
    check("s1_irq_set", 64'(irq_o), 64'd1);
    wait_period(0, 9);
    check("s1_reloaded", 64'(budget_left_o[0]), 64'd100);
    irq_clear_i[0] = 1'b1;
    step();
    irq_clear_i = '0;
    check("s1_irq_cleared", 64'(irq_o), 64'd0);

    // Carry-over accumulation capped at 2x budget (slot 2: m0 r1 read)
    cfg(2, 1'b1, 1'b1, 100, 10);
    step();
    check("s2_reload_0", 64'(budget_left_o[2]), 64'd100);
    req(0, 1, 30); step(); cons_valid_i = '0;
    wait_period(2, 9);
    check("s2_reload_1", 64'(budget_left_o[2]), 64'd170);
    req(0, 1, 30); step(); cons_valid_i = '0;
    wait_period(2, 9);
    check("s2_reload_2", 64'(budget_left_o[2]), 64'd200);

    // Consume in the reload cycle uses the pre-reload budget (slot 4: m0 r2 read)
    cfg(4, 1'b1, 1'b0, 100, 4);
    step();
    req(0, 2, 90); step(); cons_valid_i = '0;
    check("s3_left_10", 64'(budget_left_o[4]), 64'd10);
    wait_period(4, 0);
    req(0, 2, 50);
    #1 check("s3_ready_prereload", 64'(cons_ready_o[0]), 64'd0);
    step();
    cons_valid_i = '0;
    check("s3_after_reload", 64'(budget_left_o[4]), 64'd100);

    // Zero-length period: reload every cycle (slot 1: m0 r0 write)
    cfg(1, 1'b1, 1'b0, 8, 0);
    req(1, 0, 8);
    repeat (6) step();
    req(1, 0, 0);
    #1 check("s4_zero_byte_grant", 64'(cons_ready_o[1]), 64'd1);
    cons_valid_i = '0;

    // Disable mid-period, then re-enable
    enable_i[2] = 1'b0;
    step();
    check("s5_bl_cleared", 64'(budget_left_o[2]), 64'd0);
    check("s5_pl_cleared", 64'(period_left_o[2]), 64'd0);
    req(0, 1, 1000);
    #1 check("s5_ready_disabled", 64'(cons_ready_o[0]), 64'd1);
    cons_valid_i = '0;
    enable_i[2] = 1'b1;
    step();
    check("s5_reenable_pl", 64'(period_left_o[2]), 64'd9);
    check("s5_reenable_bl", 64'(budget_left_o[2]), 64'd100);

    // Reset clears pending; outside reset set beats clear
    req(0, 2, 200);
    step();
    rst_i = 1'b1;
    irq_clear_i[4] = 1'b1;
    step();
    rst_i = 1'b0;
    check("s6_reset_irq", 64'(irq_o), 64'd0);
    step();
    check("s6_set_wins", 64'(irq_o), 64'd1);
    cons_valid_i = '0;
    irq_clear_i = '1;
    step();
    irq_clear_i = '0;

    // Random traffic and configuration churn
    for (int s = 0; s < NS; s++) begin
      cfg(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 200), $urandom_range(0, 12));
    end
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        int s;
        s = int'($urandom_range(0, NS - 1));
        cfg(s, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) == 0) ? 32'hFFFF_FF00 + $urandom_range(0, 255)
                                        : $urandom_range(0, 200),
            $urandom_range(0, 12));
      end
      for (int k = 0; k < NK; k++) begin
        cons_valid_i[k]  = 1'($urandom_range(0, 1));
        cons_region_i[k] = RW'($urandom_range(0, NR - 1));
        cons_bytes_i[k]  = ($urandom_range(0, 7) == 0) ? '0 : BW'($urandom_range(1, 160));
      end
      for (int s = 0; s < NS; s++) irq_clear_i[s] = ($urandom_range(0, 7) == 0);
      rst_i = ($urandom_range(0, 99) == 0);
      step();
    end
    rst_i = 1'b0;
    cons_valid_i = '0;
    irq_clear_i = '0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
